mult32x32_arbiter: RTL and testbench
====================================

Name: mult32x32_arbiter

Overview:
- Round-robin scheduler that shares one mult32x32_fast instance among N_REQ requesters.
- Accepts operand pairs over a valid/ready handshake and sequences the multiplier's start/busy protocol.
- Returns the 64-bit product to the granted requester over a valid/ready response handshake.
- Sits between the requesting blocks and the multiplier; it owns the multiplier's start/a/b inputs exclusively.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT, 16, max cycles in WAIT before abort; 0 disables the watchdog

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  N_REQ  per-requester request valid
req_a  in  N_REQ*32  operand a, requester i at bits [32i+31:32i]
req_b  in  N_REQ*32  operand b, same packing
req_ready  out  N_REQ  one-hot accept strobe
rsp_valid  out  N_REQ  one-hot response valid
rsp_ready  in  N_REQ  per-requester response accept
rsp_product  out  64  product for the responding requester
rsp_error  out  1  qualifies rsp_valid; 1 = watchdog abort, product 0
mul_start  out  1  one-cycle start pulse to the multiplier
mul_a  out  32  latched operand a
mul_b  out  32  latched operand b
mul_busy  in  1  multiplier busy
mul_product  in  64  multiplier result

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high and takes priority over everything, including mid-operation.
- Reset values: state=IDLE, req_ready=0, rsp_valid=0, rsp_product=0, rsp_error=0, mul_start=0, mul_a=0, mul_b=0, rr pointer=0 (requester 0 highest priority), watchdog=0.
- Reset during START or WAIT abandons the in-flight operation. No response is issued. The multiplier is not re-reset by this block.
- Multiplier contract: start is sampled on one edge. busy is high from the next cycle until the result is ready. The first cycle with busy=0 after start has a valid mul_product.
- IDLE:
  - grant = first i with req_valid[i]=1, searching from rr pointer upward mod N_REQ.
  - req_ready[grant]=1 combinationally in this cycle; all other bits are 0.
  - On the edge: latch req_a/req_b of grant into mul_a/mul_b, register grant, go to START.
  - No valid requests: stay in IDLE.
- START:
  - mul_start=1 for exactly one cycle; mul_a/mul_b stable.
  - Go to WAIT; clear the watchdog.
- WAIT:
  - mul_busy is ignored in the first WAIT cycle; the multiplier raises it there.
  - From the second WAIT cycle, mul_busy=0 captures mul_product into rsp_product, sets rsp_error=0, goes to RESP.
  - The watchdog increments each WAIT cycle. If TIMEOUT≠0 and it reaches TIMEOUT: rsp_product=0, rsp_error=1, go to RESP.
- RESP:
  - rsp_valid[grant]=1 until rsp_ready[grant]=1.
  - rsp_product/rsp_error are held constant while rsp_valid is high.
  - rsp_ready on non-granted bits is ignored.
  - On handshake: rr pointer = (grant+1) mod N_REQ, go to IDLE.
- mul_a/mul_b hold their last value outside START/WAIT.
- Latency with multiplier busy for L cycles:
  - Accept at cycle 0, mul_start at cycle 1.
  - Capture at the first busy-low cycle, earliest cycle 3.
  - rsp_valid high from the following cycle.
  - With rsp_ready held high, the next request is accepted the cycle after the response handshake.
- Only one operation is in flight; no request is accepted outside IDLE.
- req_valid from non-granted requesters is ignored (no ready) until they win arbitration.
- Simultaneous events:
  - All requesters valid: strict rotation 0,1,2,3,0,...
  - A requester dropping req_valid before being granted is never served.
  - A requester re-asserting right after its response waits behind the others.

Test Plan:
- Single request: reset 4 cycles, requester 0 sends a=0x0000FFFF, b=0x0000FFFF, rsp_ready=1 → req_ready[0] 1 cycle, mul_start 1 cycle later, rsp_valid[0] with rsp_product=0x00000000FFFE0001, rsp_error=0.
- Width check: requester 2 sends a=b=0x0001FFFF → rsp_valid[2] with rsp_product=0x00000003FFFC0001; then a=b=0xFFFFFFFF → 0xFFFFFFFE00000001.
- Round-robin: all 4 valid continuously with distinct operands (a=i+1, b=0x10) → grants in order 0,1,2,3,0; each response goes only to its owner with product 0x10*(i+1); exactly one mul_start per grant.
- Backpressure: rsp_ready[1]=0 for 5 cycles → rsp_valid[1] and rsp_product held stable, no new req_ready or mul_start until handshake.
- Watchdog: model holds mul_busy=1 forever, TIMEOUT=16 → rsp_valid with rsp_error=1, rsp_product=0 after 16 WAIT cycles; next request proceeds normally.
- Reset mid-operation: assert reset while in WAIT → next cycle all outputs 0, no rsp_valid; a new request from requester 3 after reset is granted over requester 0 only if requester 0 is not valid.

Source files
------------

// File: rtl/mult32x32_arbiter.sv
// rtl/mult32x32_arbiter.sv - round-robin scheduler sharing one 32x32 multiplier among N_REQ requesters
module mult32x32_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*32-1:0] req_a,
    input  logic [N_REQ*32-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   rsp_valid,
    input  logic [N_REQ-1:0]   rsp_ready,
    output logic [63:0]        rsp_product,
    output logic               rsp_error,
    output logic               mul_start,
    output logic [31:0]        mul_a,
    output logic [31:0]        mul_b,
    input  logic               mul_busy,
    input  logic [63:0]        mul_product
);

    localparam int GW = (N_REQ <= 2) ? 1 : $clog2(N_REQ);
    localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   pick;
    logic            pick_ok;
    logic [WW-1:0]   watchdog;
    logic            first_wait;
    logic            capture;
    logic            abort;
    logic            wd_hit;

    // Descending scan so the requester closest to rr_ptr is assigned last and wins.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                pick    = GW'((int'(rr_ptr) + k) % N_REQ);
                pick_ok = 1'b1;
            end
        end
    end

    assign wd_hit  = (TIMEOUT != 0) && ((int'(watchdog) + 1) >= TIMEOUT);
    // busy is not yet meaningful in the first WAIT cycle; the multiplier raises it there.
    assign capture = (state == WAIT) && !first_wait && !mul_busy;
    assign abort   = (state == WAIT) && !capture && wd_hit;

    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = '0;
        mul_start  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_ok && !reset) begin
                    req_ready[pick] = 1'b1;
                    state_next      = START;
                end
            end
            START: begin
                mul_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (capture || abort) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid[grant] = 1'b1;
                if (rsp_ready[grant]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            rsp_product <= '0;
            rsp_error   <= 1'b0;
            watchdog    <= '0;
            first_wait  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (pick_ok) begin
                        grant <= pick;
                        mul_a <= req_a[int'(pick) * 32 +: 32];
                        mul_b <= req_b[int'(pick) * 32 +: 32];
                    end
                end
                START: begin
                    watchdog   <= '0;
                    first_wait <= 1'b1;
                end
                WAIT: begin
                    first_wait <= 1'b0;
                    if (watchdog != '1) begin
                        watchdog <= watchdog + 1'b1;
                    end
                    if (capture) begin
                        rsp_product <= mul_product;
                        rsp_error   <= 1'b0;
                    end else if (abort) begin
                        rsp_product <= '0;
                        rsp_error   <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready[grant]) begin
                        rr_ptr <= GW'((int'(grant) + 1) % N_REQ);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult32x32_arbiter.sv
// tb/tb_mult32x32_arbiter.sv - scoreboard bench for mult32x32_arbiter with a behavioural multiplier
module tb_mult32x32_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [63:0]     rsp_product;
    logic            rsp_error;
    logic            mul_start;
    logic [31:0]     mul_a;
    logic [31:0]     mul_b;
    logic            mul_busy;
    logic [63:0]     mul_product;

    always #5 clk = ~clk;

    mult32x32_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product), .rsp_error(rsp_error),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_busy(mul_busy), .mul_product(mul_product)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // behavioural multiplier: busy for lat cycles after start, forever while hang is set
    int          lat      = 1;
    bit          hang     = 1'b0;
    int          busy_cnt = 0;
    logic [63:0] mprod    = '0;

    always @(posedge clk) begin
        if (mul_start) begin
            busy_cnt <= lat;
            mprod    <= {32'b0, mul_a} * {32'b0, mul_b};
        end else if (busy_cnt > 0 && !hang) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign mul_busy    = (busy_cnt != 0);
    assign mul_product = mprod;

    typedef struct {
        int          id;
        logic [63:0] prod;
        bit          err;
    } exp_t;

    exp_t        sbq[$];
    int          grant_log[$];
    logic [31:0] op_a[N];
    logic [31:0] op_b[N];
    int          cyc = 0;
    int          m_rr = 0;
    int          acc_cyc, start_cyc, exp_lat, n_start;
    bit          rsp_seen;
    logic [63:0] held_p;
    logic        held_e;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int exp_grant(input logic [N-1:0] v, input int rr);
        for (int k = 0; k < N; k++) begin
            if (v[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int   id;
        exp_t e;
        if (reset) begin
            sbq.delete();
            m_rr     = 0;
            rsp_seen = 1'b0;
        end else begin
            if (req_ready != '0) begin
                id = idx_of(req_ready);
                check_eq("req_ready_onehot", 64'($onehot(req_ready)), 64'd1);
                check_eq("req_ready_without_valid", 64'(req_ready & ~req_valid), 64'd0);
                check_eq("grant_order", 64'(id), 64'(exp_grant(req_valid, m_rr)));
                e.id   = id;
                e.err  = hang;
                e.prod = hang ? 64'd0 : {32'b0, op_a[id]} * {32'b0, op_b[id]};
                sbq.push_back(e);
                grant_log.push_back(id);
                acc_cyc = cyc;
            end
            if (mul_start) begin
                check_eq("accept_to_start", 64'(cyc - acc_cyc), 64'd1);
                start_cyc = cyc;
                exp_lat   = hang ? TO + 1 : lat + 2;
                n_start++;
            end
            if (rsp_valid != '0) begin
                check_eq("quiet_while_rsp", 64'({req_ready, mul_start}), 64'd0);
                if (!rsp_seen) begin
                    rsp_seen = 1'b1;
                    check_eq("latency", 64'(cyc - start_cyc), 64'(exp_lat));
                    held_p = rsp_product;
                    held_e = rsp_error;
                end else begin
                    check_eq("hold_product", rsp_product, held_p);
                    check_eq("hold_error", 64'(rsp_error), 64'(held_e));
                end
                if ((rsp_valid & rsp_ready) != '0) begin
                    id = idx_of(rsp_valid);
                    if (sbq.size() == 0) begin
                        check_eq("unexpected_rsp", 64'(id), 64'hFFFF);
                    end else begin
                        e = sbq.pop_front();
                        check_eq("rsp_owner", 64'(rsp_valid), 64'(1 << e.id));
                        check_eq("rsp_product", rsp_product, e.prod);
                        check_eq("rsp_error", 64'(rsp_error), 64'(e.err));
                    end
                    rsp_seen = 1'b0;
                    m_rr     = (id + 1) % N;
                end
            end
        end
    end

    task automatic send(input int id, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        op_a[id]             = a;
        op_b[id]             = b;
        req_a[id*32 +: 32]   = a;
        req_b[id*32 +: 32]   = b;
        req_valid[id]        = 1'b1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                @(posedge clk);
                #1;
                req_valid[id] = 1'b0;
                return;
            end
        end
        check_eq("accept_timeout", 64'(id), 64'hFFFF);
        req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (sbq.size() == 0 && rsp_valid == '0) return;
        end
        check_eq("drain_timeout", 64'(sbq.size()), 64'd0);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check_eq({tag, "_rsp_product"}, rsp_product, 64'd0);
        check_eq({tag, "_rsp_error"}, 64'(rsp_error), 64'd0);
        check_eq({tag, "_mul_start"}, 64'(mul_start), 64'd0);
        check_eq({tag, "_mul_a"}, 64'(mul_a), 64'd0);
        check_eq({tag, "_mul_b"}, 64'(mul_b), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '1;
        n_start   = 0;
        rsp_seen  = 1'b0;
        acc_cyc   = 0;
        start_cyc = 0;
        exp_lat   = 0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_quiet("reset");

        lat = 1;
        send(0, 32'h0000FFFF, 32'h0000FFFF);
        drain();
        check_eq("single_product", rsp_product, 64'h00000000FFFE0001);

        lat = 3;
        send(2, 32'h0001FFFF, 32'h0001FFFF);
        drain();
        check_eq("width_product_1", rsp_product, 64'h00000003FFFC0001);
        send(2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        drain();
        check_eq("width_product_2", rsp_product, 64'hFFFFFFFE00000001);
        send(3, 32'd5, 32'd7);
        drain();

        // all four requesters valid continuously, each asking twice
        lat = 2;
        grant_log.delete();
        n_start = 0;
        fork
            begin send(0, 32'd1, 32'h10); send(0, 32'd1, 32'h10); end
            begin send(1, 32'd2, 32'h10); send(1, 32'd2, 32'h10); end
            begin send(2, 32'd3, 32'h10); send(2, 32'd3, 32'h10); end
            begin send(3, 32'd4, 32'h10); send(3, 32'd4, 32'h10); end
        join
        drain();
        check_eq("rr_count", 64'(grant_log.size()), 64'd8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++) begin
            check_eq("rr_sequence", 64'(grant_log[k]), 64'(k % 4));
        end
        check_eq("rr_starts", 64'(n_start), 64'd8);

        // response backpressure on requester 1 while requester 0 is waiting
        rsp_ready[1] = 1'b0;
        send(1, 32'h1234, 32'h5678);
        for (int t = 0; t < 50 && !rsp_valid[1]; t++) @(negedge clk);
        check_eq("bp_rsp_valid", 64'(rsp_valid), 64'b0010);
        fork
            send(0, 32'd3, 32'd3);
            begin
                repeat (5) @(negedge clk);
                check_eq("bp_still_valid", 64'(rsp_valid), 64'b0010);
                @(posedge clk);
                #1 rsp_ready[1] = 1'b1;
            end
        join
        drain();

        // watchdog abort, then a normal operation
        hang = 1'b1;
        send(2, 32'd7, 32'd9);
        drain();
        check_eq("wd_error", 64'(rsp_error), 64'd1);
        hang = 1'b0;
        send(3, 32'd6, 32'd7);
        drain();
        check_eq("after_wd_product", rsp_product, 64'd42);

        // reset while the operation sits in WAIT
        hang = 1'b1;
        send(2, 32'd4, 32'd4);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        hang = 1'b0;
        @(negedge clk);
        check_quiet("midreset");
        repeat (3) @(negedge clk);
        check_eq("midreset_no_rsp", 64'(rsp_valid), 64'd0);
        grant_log.delete();
        fork
            send(3, 32'd11, 32'd2);
            send(0, 32'd13, 32'd2);
        join
        drain();
        send(3, 32'd17, 32'd2);
        drain();
        check_eq("post_reset_count", 64'(grant_log.size()), 64'd3);
        if (grant_log.size() == 3) begin
            check_eq("post_reset_first", 64'(grant_log[0]), 64'd0);
            check_eq("post_reset_second", 64'(grant_log[1]), 64'd3);
            check_eq("post_reset_third", 64'(grant_log[2]), 64'd3);
        end
        check_eq("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
